unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the CPU's instruction-fetch stage and its data-access (MEM) stage.
- Accepts req/ready handshakes from both requesters and issues one transaction at a time to the memory.
- Routes the memory response back to the requester that owns the transaction.
- Aborts with an error pulse if the memory does not answer within a bounded number of cycles.
- Sits between the pipeline stages and the memory model; the pipeline stalls a stage while its req is high and ready is low.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width; byte enables are DATA_WIDTH/8 bits
TIMEOUT, 16, maximum cycles in WAIT before abort; must be >= 1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_ready
if_addr  in  ADDR_WIDTH  fetch byte address
if_ready  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch response valid (one-cycle pulse)
if_rdata  out  DATA_WIDTH  fetch read data
if_err  out  1  fetch timed out (one-cycle pulse)
d_req  in  1  data request; fields held stable until d_ready
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_WIDTH/8  byte enables (sb = one bit, sh = two bits, sw = all bits)
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  store data, already lane-aligned
d_ready  out  1  data request accepted this cycle
d_rvalid  out  1  data response valid (loads and store acks)
d_rdata  out  DATA_WIDTH  load data
d_err  out  1  data access timed out (one-cycle pulse)
mem_req  out  1  request to memory (one-cycle pulse)
mem_we  out  1  write strobe
mem_be  out  DATA_WIDTH/8  byte enables
mem_addr  out  ADDR_WIDTH  address
mem_wdata  out  DATA_WIDTH  write data
mem_rvalid  in  1  memory response/ack; one per mem_req, 1..N cycles after it
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_rvalid

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding. Registered owner (IF or D) and a timeout counter.
- Reset: state=IDLE, owner=IF, last_owner=IF, counter=0. All outputs are 0: mem_*, *_ready, *_rvalid, *_rdata, *_err.
- IDLE arbitration (combinational on req inputs):
  - Only one req high: that requester wins.
  - Both high: the requester != last_owner wins. The first conflict after reset therefore goes to D.
- Grant cycle (IDLE with a winner):
  - mem_req=1.
  - mem_we/mem_be/mem_addr/mem_wdata driven from the winner. For IF: we=0, be=all ones, wdata=0.
  - Winner's *_ready=1; the loser's ready=0.
  - Next state WAIT; owner and last_owner <= winner; counter <= 0.
- Outside the grant cycle: mem_req=0 and the mem_* fields are 0.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid: owner's *_rvalid=1 and *_rdata=mem_rdata, registered, so visible the cycle after mem_rvalid. Next state IDLE.
  - No grant occurs in the cycle mem_rvalid arrives.
- Minimum issue-to-issue spacing = memory latency + 2 cycles.
- Timeout:
  - If the counter reaches TIMEOUT-1 without mem_rvalid, the owner's *_err pulses 1 the next cycle and state returns to IDLE.
  - If mem_rvalid arrives in that same cycle, the response wins and no err is raised.
- *_rdata holds its last value between pulses. The non-owner's rvalid/rdata/err are never touched.
- mem_rvalid in IDLE (spurious, or late after a timeout or reset): ignored, no output change.
- Requests raised while in WAIT: held pending, not dropped; arbitrated on return to IDLE.
- Reset mid-transaction: the outstanding transaction is abandoned with no rvalid/err. A late mem_rvalid is ignored per the IDLE rule.
- req deasserted before ready: permitted only while not granted; no state effect.
- Store ack: the response to a store is d_rvalid=1 with d_rdata=mem_rdata, content don't-care for requesters.

Test Plan:
1. Reset, then if_req=1, if_addr=0x0; memory latency 1 → cycle0 mem_req=1 with addr 0x0, if_ready=1; cycle1 mem_rvalid with rdata 0x00000083; cycle2 if_rvalid=1, if_rdata=0x00000083.
2. Both if_req and d_req high from reset (d: we=0, be=4'b0001, addr=0x0) → D granted first; IF granted at the next IDLE. Then with both held, grants alternate D, IF, D, IF across 4 transactions.
3. Store d_we=1, d_be=4'b0001, d_addr=0x4, d_wdata=0x000000ff → mem_we=1, mem_be=4'b0001, mem_addr=0x4, mem_wdata=0xff in the grant cycle; d_rvalid pulses once; if_rvalid stays 0.
4. TIMEOUT=4, memory never answers a fetch → if_err=1 exactly 4 cycles after the grant, state IDLE. A pending d_req is granted the next cycle. A late mem_rvalid afterwards produces no rvalid.
5. Grant a data load, assert reset in the WAIT state, then drive mem_rvalid → no d_rvalid/d_err; all outputs 0; after reset, if_req is granted normally.
6. mem_rvalid pulsed in IDLE with no requests → no *_rvalid/*_err, mem_req stays 0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch (IF) stage and
// the data-access (D) stage. One transaction is outstanding at a time.
//
// Handshake: a requester raises *_req with its fields stable and keeps them
// stable until *_ready is high in the same cycle. That cycle is the grant and
// the memory request (mem_req) pulses in it. The memory answers with exactly
// one mem_rvalid 1..N cycles later. The answer reaches the owning requester
// one cycle after that as a one-cycle *_rvalid pulse.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   if_req/if_addr                fetch request (read of a full word)
//   if_ready/if_rvalid/if_rdata   fetch accept / response pulse / read data
//   if_err                        fetch timeout pulse
//   d_req/d_we/d_be/d_addr/d_wdata  data request (load or store)
//   d_ready/d_rvalid/d_rdata      data accept / response pulse / load data
//   d_err                         data timeout pulse
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  one-cycle request to memory
//   mem_rvalid/mem_rdata          memory response
//   dbg_state                     current FSM state (0 = IDLE, 1 = WAIT)
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [0:0]              dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // The abort decision is taken in the WAIT cycle whose increment brings the
  // counter to TIMEOUT-1, so the err pulse lands TIMEOUT cycles after the
  // grant. With TIMEOUT=1 the first WAIT cycle is already at the limit.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LIMIT = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);

  logic [0:0]       state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] cnt;
  // High for the single IDLE cycle in which a response or err is presented.
  // Issue is held off in that cycle, so back-to-back issues are spaced by
  // the memory latency plus two cycles.
  logic             resp_hold;

  logic grant;
  logic win_d;
  logic timeout_hit;

  // Round-robin on conflict: whoever did not own the last transaction wins.
  assign win_d       = d_req && (!if_req || (last_owner == OWNER_IF));
  assign grant       = (state == ST_IDLE) && !resp_hold && !reset && (if_req || d_req);
  assign timeout_hit = (cnt >= CNT_LIMIT);
  assign dbg_state   = state;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    if (grant) begin
      mem_req = 1'b1;
      if (win_d) begin
        d_ready   = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        if_ready  = 1'b1;
        mem_be    = '1;
        mem_addr  = if_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWNER_IF;
      last_owner <= OWNER_IF;
      cnt        <= '0;
      resp_hold  <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      resp_hold <= 1'b0;
      case (state)
        ST_IDLE: begin
          // mem_rvalid is deliberately ignored here: nothing is outstanding.
          if (grant) begin
            state      <= ST_WAIT;
            owner      <= win_d ? OWNER_D : OWNER_IF;
            last_owner <= win_d ? OWNER_D : OWNER_IF;
            cnt        <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            // A response in the abort cycle still counts as a response.
            state     <= ST_IDLE;
            resp_hold <= 1'b1;
            if (owner == OWNER_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state     <= ST_IDLE;
            resp_hold <= 1'b1;
            if (owner == OWNER_D) d_err  <= 1'b1;
            else                  if_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
